rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//   Shares the single flash ROM read port (stb/we/addr -> data_out/ack, 32-bit words,
//   ~26 clk per word) among N_REQ requesters (e.g. boot loader, CPU fetch, video).
//   Round-robin grant, one ROM transaction in flight, write requests rejected,
//   timeout watchdog on a missing ack. Sits between requester buses and the rom block.
// PARAMETERS
//   N_REQ      2     number of requester ports (2..4)
//   TIMEOUT    63    clk cycles in BUSY without rom_ack before error-completion
// PORTS
//   clk           in   1          system clock, all logic on rising edge
//   rst_n         in   1          asynchronous, active-low reset
//   req_stb       in   N_REQ      per-requester strobe, held until its ack
//   req_we        in   N_REQ      per-requester write flag (unsupported -> error)
//   req_addr      in   N_REQ*21   word addresses [22:2], requester i at [21*i+:21]
//   req_data      out  32         read data, shared, valid when any req_ack bit high
//   req_ack       out  N_REQ      one-cycle completion pulse, one-hot
//   req_err       out  1          qualifies req_ack: 1 = write or timeout, data = 0
//   rom_stb       out  1          to rom stb
//   rom_we        out  1          to rom we, constant 0
//   rom_addr      out  21         to rom addr[22:2]
//   rom_data      in   32         from rom data_out
//   rom_ack       in   1          from rom ack (one-cycle pulse)
//   flush         in   1          invalidate line buffer (ROM_ARB_LINEBUF_EN only)
// BEHAVIOUR
//   Reset: state IDLE, rom_stb=0, rom_we=0, rom_addr=0, req_ack=0, req_err=0,
//     req_data=0, rr pointer=0, timeout count=0, line buffer invalid.
//   FSM IDLE -> BUSY -> DONE -> IDLE; all outputs registered.
//   IDLE: pick winner among req_stb, round-robin starting at pointer; none -> stay.
//     winner we=1 -> DONE, req_ack[w]=1, req_err=1, req_data=0, no ROM access.
//     winner we=0 -> BUSY, rom_stb<=1, rom_addr<=req_addr[w], count<=0.
//     pointer <= w+1 (mod N_REQ) on every grant, including error grants.
//   BUSY: count++ each cycle. rom_ack=1 -> rom_stb<=0, req_data<=rom_data,
//     req_ack[w]<=1, req_err<=0, -> DONE. rom_stb drops at the same edge the ROM
//     leaves ack state, so the ROM cannot relaunch.
//     count==TIMEOUT and no rom_ack -> rom_stb<=0, ack with req_err=1, -> DONE.
//     rom_ack and timeout on same cycle -> normal completion wins.
//   DONE: req_ack/req_err high exactly this cycle; req_stb not sampled; clear -> IDLE.
//   Requester protocol: hold stb/we/addr stable until ack, drop stb at the ack edge;
//     stb still high in the IDLE after DONE = new request.
//   Granted requester dropping stb while BUSY: transaction finishes, ack issued anyway.
//   Latency (no buffer hit): req_stb seen -> rom_stb +1 clk; rom_ack -> req_ack +1 clk.
//   Async reset mid-transaction: FSM to IDLE immediately, rom_stb=0; the rom block
//     must be reset in the same cycle (system reset tree guarantees this).
//   Full-word addressing only; a[1:0] byte sequencing stays inside the rom block.
// CONFIGURATION
//   ROM_ARB_LINEBUF_EN defined: 1-entry buffer {valid, addr[22:2], data[31:0]} loaded
//     on every successful ROM read. IDLE grant with we=0 and addr==buf addr and valid
//     -> DONE directly with buffered data (2 clk req->ack), no rom_stb.
//     flush=1 clears valid; flush same cycle as load -> valid ends 0.
//   Not defined: no buffer, every read goes to ROM, flush input ignored.
// STRUCTURE
//   Package rom_arb_pkg: state enum {IDLE,BUSY,DONE}, ROM_AW=21, ROM_DW=32,
//     TIMEOUT_W=6 counter width.
//   Sub-module rr_arbiter (N_REQ request vector + pointer -> one-hot grant, index);
//     FSM, timeout counter and line buffer stay in rom_arbiter.
// TESTING (bench uses behavioural rom model, 26-clk read)
//   Single read req0 addr 0x000010, ROM word 0xDEADBEEF -> rom_addr=0x000010,
//     req_ack[0] 1 clk after rom_ack, req_data=0xDEADBEEF, req_err=0.
//   req0 and req1 both held, 4 reads each -> grants alternate 0,1,0,1..., no lost ack.
//   req1 we=1 -> req_ack[1]=1, req_err=1, req_data=0 within 2 clk, rom_stb never high.
//   ROM model withholds ack -> req_err=1 ack exactly TIMEOUT+1 clk after grant.
//   rst_n low during BUSY -> rom_stb=0 and all acks 0 same cycle; clean read after.
//   With ROM_ARB_LINEBUF_EN: read 0x000020 twice -> 2nd acks in 2 clk, no rom_stb;
//     flush then read again -> full ROM access.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and state encoding for the flash ROM read-port arbiter.
package rom_arb_pkg;
  localparam int ROM_AW    = 21;
  localparam int ROM_DW    = 32;
  localparam int TIMEOUT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: N_REQ strobed word-read ports sharing one data/ack return.
// Handshake: a requester raises req_stb[i] with req_we[i]/req_addr[i] stable and holds them until
// req_ack[i] pulses for one cycle; req_err qualifies that pulse and req_data is valid only with it.
interface rom_arbiter_if #(
  parameter int N_REQ = 2
);
  import rom_arb_pkg::*;

  logic [N_REQ-1:0]        req_stb;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ROM_AW-1:0] req_addr;
  logic [ROM_DW-1:0]       req_data;
  logic [N_REQ-1:0]        req_ack;
  logic                    req_err;

  modport master (
    output req_stb, req_we, req_addr,
    input  req_data, req_ack, req_err
  );

  modport slave (
    input  req_stb, req_we, req_addr,
    output req_data, req_ack, req_err
  );
endinterface

// File: rtl/rom_arbiter_rr.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Upper segment [ptr..N_REQ-1] has priority, then wrap to [0..ptr-1].
    for (int j = 0; j < N_REQ; j++) begin
      if (!valid && req[j] && (j >= int'(ptr))) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
    grant = valid ? (N_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of the single flash ROM read port, with write rejection and ack watchdog.
// Optional 1-entry line buffer enabled by defining ROM_ARB_LINEBUF_EN.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_arbiter_if.slave      bus,
  output logic              rom_stb,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  input  logic              rom_ack,
  input  logic              flush,
  output logic [1:0]        dbg_state
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]           state;
  logic [IW-1:0]        ptr;
  logic [N_REQ-1:0]     win_oh;
  logic [TIMEOUT_W-1:0] count;

  logic [N_REQ-1:0]     gnt_oh;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic [IW-1:0]        ptr_nxt;
  logic [ROM_AW-1:0]    win_addr;
  logic                 win_we;
  logic                 buf_hit;
  logic [ROM_DW-1:0]    hit_data;
  logic                 rom_load;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_stb),
    .ptr   (ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_comb begin
    win_addr = '0;
    win_we   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_oh[j]) begin
        win_addr = bus.req_addr[j*ROM_AW +: ROM_AW];
        win_we   = bus.req_we[j];
      end
    end
  end

  assign ptr_nxt   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  assign rom_load  = (state == S_BUSY) && rom_ack;
  assign rom_we    = 1'b0;
  assign dbg_state = state;

`ifdef ROM_ARB_LINEBUF_EN
  logic              buf_valid;
  logic [ROM_AW-1:0] buf_addr;
  logic [ROM_DW-1:0] buf_data;

  assign buf_hit  = buf_valid && (buf_addr == win_addr);
  assign hit_data = buf_data;

  // Flush takes priority over a load in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      if (rom_load) begin
        buf_addr <= rom_addr;
        buf_data <= rom_data;
      end
      if (flush)         buf_valid <= 1'b0;
      else if (rom_load) buf_valid <= 1'b1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign buf_hit      = 1'b0;
  assign hit_data     = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      win_oh       <= '0;
      count        <= '0;
      rom_stb      <= 1'b0;
      rom_addr     <= '0;
      bus.req_ack  <= '0;
      bus.req_err  <= 1'b0;
      bus.req_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            ptr    <= ptr_nxt;
            win_oh <= gnt_oh;
            if (win_we) begin
              state        <= S_DONE;
              bus.req_ack  <= gnt_oh;
              bus.req_err  <= 1'b1;
              bus.req_data <= '0;
            end else if (buf_hit) begin
              state        <= S_DONE;
              bus.req_ack  <= gnt_oh;
              bus.req_err  <= 1'b0;
              bus.req_data <= hit_data;
            end else begin
              state    <= S_BUSY;
              rom_stb  <= 1'b1;
              rom_addr <= win_addr;
              count    <= '0;
            end
          end
        end
        S_BUSY: begin
          count <= count + TIMEOUT_W'(1);
          // A real ack beats a coincident timeout.
          if (rom_ack) begin
            state        <= S_DONE;
            rom_stb      <= 1'b0;
            bus.req_ack  <= win_oh;
            bus.req_err  <= 1'b0;
            bus.req_data <= rom_data;
          end else if (count == TIMEOUT_W'(TIMEOUT)) begin
            state        <= S_DONE;
            rom_stb      <= 1'b0;
            bus.req_ack  <= win_oh;
            bus.req_err  <= 1'b1;
            bus.req_data <= '0;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          bus.req_ack <= '0;
          bus.req_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 26-clk flash ROM model.
module tb_rom_arbiter;
  localparam int N_REQ = 2;
  localparam int TIMEOUT = 63;

  logic        clk;
  logic        rst_n;
  logic        rom_stb;
  logic        rom_we;
  logic [20:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ack;
  logic        flush;
  logic [1:0]  dbg_state;
  logic        rom_withhold;
  int          rom_cnt;

  int checks;
  int errors;
  int ptr_model;
  logic [32:0] exp_q[$];

  typedef struct {
    int          idx;
    logic        we;
    logic [20:0] addr;
    logic        hold;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_rom;
  } vec_t;

  vec_t vecs[8];

  rom_arbiter_if #(.N_REQ(N_REQ)) bus ();

  rom_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rom_stb   (rom_stb),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ack   (rom_ack),
    .flush     (flush),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [20:0] a);
    if (a == 21'h000010) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ {11'b0, a};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cnt  <= 0;
      rom_ack  <= 1'b0;
      rom_data <= '0;
    end else if (rom_ack) begin
      rom_ack <= 1'b0;
      rom_cnt <= 0;
    end else if (rom_stb && !rom_withhold) begin
      if (rom_cnt == 25) begin
        rom_ack  <= 1'b1;
        rom_data <= rom_word(rom_addr);
        rom_cnt  <= 0;
      end else begin
        rom_cnt <= rom_cnt + 1;
      end
    end else begin
      rom_cnt <= 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_stb  = '0;
    bus.req_we   = '0;
    bus.req_addr = '0;
    flush        = 1'b0;
    rom_withhold = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    ptr_model = 0;
    @(negedge clk);
  endtask

  task automatic do_txn(input int i, input logic we, input logic [20:0] addr, input logic hold,
                        input logic exp_err, input logic [31:0] exp_data, input int exp_lat,
                        input logic exp_rom, input string name);
    int lat;
    bit got;
    bit rom_seen;
    bit addr_ok;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] data_v;
    @(negedge clk);
    rom_withhold = hold;
    bus.req_we[i] = we;
    bus.req_addr[i*21 +: 21] = addr;
    bus.req_stb[i] = 1'b1;
    lat = 0; got = 0; rom_seen = 0; addr_ok = 1;
    ack_v = '0; err_v = 1'b0; data_v = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (rom_stb) begin
        rom_seen = 1;
        if (rom_addr !== addr) addr_ok = 0;
      end
      if (bus.req_ack != '0) begin
        got = 1;
        ack_v = bus.req_ack; err_v = bus.req_err; data_v = bus.req_data;
      end
    end
    check({name, "_got_ack"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_ack_vec"}, 64'(ack_v), 64'(2'b01 << i));
    check({name, "_err"}, 64'(err_v), 64'(exp_err));
    check({name, "_data"}, 64'(data_v), 64'(exp_data));
    check({name, "_rom_used"}, 64'(rom_seen), 64'(exp_rom));
    if (rom_seen) check({name, "_rom_addr"}, 64'(addr_ok), 64'd1);
    bus.req_stb[i] = 1'b0;
    bus.req_we[i]  = 1'b0;
    rom_withhold   = 1'b0;
    if (got) ptr_model = (i + 1) % N_REQ;
    @(negedge clk);
    check({name, "_ack_one_cycle"}, 64'(bus.req_ack), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int cnt0, cnt1, cyc, oi;
    logic [32:0] e;
    checks = 0;
    errors = 0;

    vecs[0] = '{0, 1'b0, 21'h000010, 1'b0, 1'b0, 32'hDEADBEEF, 28, 1'b1};
    vecs[1] = '{1, 1'b0, 21'h1FFFFF, 1'b0, 1'b0, 32'hC0C1FFFF, 28, 1'b1};
    vecs[2] = '{1, 1'b1, 21'h000005, 1'b0, 1'b1, 32'h00000000, 1,  1'b0};
    vecs[3] = '{0, 1'b1, 21'h000010, 1'b0, 1'b1, 32'h00000000, 1,  1'b0};
    vecs[4] = '{0, 1'b0, 21'h000000, 1'b0, 1'b0, 32'hC0DE0000, 28, 1'b1};
    vecs[5] = '{1, 1'b0, 21'h000010, 1'b0, 1'b0, 32'hDEADBEEF, 28, 1'b1};
    vecs[6] = '{0, 1'b0, 21'h0AAAAA, 1'b0, 1'b0, 32'hC0D4AAAA, 28, 1'b1};
    vecs[7] = '{0, 1'b0, 21'h000033, 1'b1, 1'b1, 32'h00000000, TIMEOUT + 2, 1'b1};

    do_reset();
    check("rst_rom_stb", 64'(rom_stb), 64'd0);
    check("rst_rom_we", 64'(rom_we), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_req_ack", 64'(bus.req_ack), 64'd0);
    check("rst_req_err", 64'(bus.req_err), 64'd0);
    check("rst_req_data", 64'(bus.req_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    for (int v = 0; v < 8; v++) begin
      do_txn(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].hold, vecs[v].exp_err,
             vecs[v].exp_data, vecs[v].exp_lat, vecs[v].exp_rom, $sformatf("vec%0d", v));
    end

    // Granted requester abandons its strobe mid-read: ack still arrives.
    @(negedge clk);
    bus.req_addr[21 +: 21] = 21'h000044;
    bus.req_stb[1] = 1'b1;
    repeat (5) @(negedge clk);
    bus.req_stb[1] = 1'b0;
    cyc = 0;
    while (bus.req_ack == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drop_stb_ack", 64'(bus.req_ack), 64'b10);
    check("drop_stb_err", 64'(bus.req_err), 64'd0);
    check("drop_stb_data", 64'(bus.req_data), 64'hC0DE0044);
    ptr_model = 0;
    repeat (2) @(negedge clk);

    // Both requesters hold strobes: grants must alternate from the pointer.
    for (int k = 0; k < 8; k++) begin
      oi = (ptr_model + k) % 2;
      exp_q.push_back({oi[0], (oi == 0) ? 32'hC0DE0100 : 32'hC0DE0200});
    end
    bus.req_addr = {21'h000200, 21'h000100};
    bus.req_stb  = 2'b11;
    cnt0 = 0; cnt1 = 0; cyc = 0;
    while ((cnt0 < 4 || cnt1 < 4) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ack != '0) begin
        check("alt_onehot", 64'($countones(bus.req_ack)), 64'd1);
        check("alt_err", 64'(bus.req_err), 64'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("alt_grant_data", 64'({bus.req_ack[1], bus.req_data}), 64'(e));
        end else begin
          check("alt_extra_ack", 64'(bus.req_ack), 64'd0);
        end
        if (bus.req_ack[0]) begin
          cnt0++;
          if (cnt0 == 4) bus.req_stb[0] = 1'b0;
        end
        if (bus.req_ack[1]) begin
          cnt1++;
          if (cnt1 == 4) bus.req_stb[1] = 1'b0;
        end
      end
    end
    check("alt_cnt0", 64'(cnt0), 64'd4);
    check("alt_cnt1", 64'(cnt1), 64'd4);
    check("alt_queue_empty", 64'(exp_q.size()), 64'd0);
    bus.req_stb = '0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while BUSY.
    bus.req_addr[0 +: 21] = 21'h000060;
    bus.req_stb[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_before_rst", 64'(rom_stb), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_rom_stb", 64'(rom_stb), 64'd0);
    check("arst_req_ack", 64'(bus.req_ack), 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    bus.req_stb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_model = 0;
    do_txn(0, 1'b0, 21'h000055, 1'b0, 1'b0, 32'hC0DE0055, 28, 1'b1, "post_rst");

`ifdef ROM_ARB_LINEBUF_EN
    do_txn(0, 1'b0, 21'h000020, 1'b0, 1'b0, 32'hC0DE0020, 28, 1'b1, "lb_fill");
    do_txn(1, 1'b0, 21'h000020, 1'b0, 1'b0, 32'hC0DE0020, 1,  1'b0, "lb_hit");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    do_txn(0, 1'b0, 21'h000020, 1'b0, 1'b0, 32'hC0DE0020, 28, 1'b1, "lb_flushed");
`else
    do_txn(0, 1'b0, 21'h000020, 1'b0, 1'b0, 32'hC0DE0020, 28, 1'b1, "nolb_first");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    do_txn(1, 1'b0, 21'h000020, 1'b0, 1'b0, 32'hC0DE0020, 28, 1'b1, "nolb_again");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
